// File: rtl/alu_result_collector.sv
// Collects registered ALU unit results into a first-word-fall-through FIFO,
// tagging each entry with its opcode, carry and flag, and flagging dropped results.
module alu_result_collector #(
    parameter int unsigned wid   = 16,
    parameter int unsigned depth = 4
) (
    input  logic                       clk,
    input  logic                       rest,
    input  logic                       op_valid,
    input  logic [3:0]                 alu_fun,
    input  logic [wid-1:0]             ari_out,
    input  logic [wid-1:0]             log_out,
    input  logic [wid-1:0]             cmp_out,
    input  logic [wid-1:0]             shift_out,
    input  logic                       carry_out,
    input  logic                       ari_flag,
    input  logic                       log_flag,
    input  logic                       cmp_flag,
    input  logic                       shift_flag,
    output logic [wid-1:0]             res_data,
    output logic [3:0]                 res_fun,
    output logic                       res_carry,
    output logic                       res_flag,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(depth+1)-1:0] count,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int unsigned ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned cnt_w = $clog2(depth + 1);

    logic             stg_valid;
    logic [3:0]       stg_fun;
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;

    logic [wid-1:0]   mem_data  [depth];
    logic [3:0]       mem_fun   [depth];
    logic             mem_carry [depth];
    logic             mem_flag  [depth];

    logic [wid-1:0]   sel_data;
    logic             sel_flag;
    logic             sel_carry;
    logic             pop;
    logic             push;
    logic             drop;

    assign empty     = (count == '0);
    assign full      = (count == cnt_w'(depth));
    assign res_valid = !empty;
    assign pop       = res_valid && res_ready;
    assign push      = stg_valid && (!full || pop);
    assign drop      = stg_valid && full && !pop;

    // Unit outputs line up with the staged opcode, one cycle after issue.
    always_comb begin
        sel_data  = ari_out;
        sel_flag  = ari_flag;
        sel_carry = carry_out;
        unique case (stg_fun[3:2])
            2'b00: begin
                sel_data  = ari_out;
                sel_flag  = ari_flag;
                sel_carry = carry_out;
            end
            2'b01: begin
                sel_data  = log_out;
                sel_flag  = log_flag;
                sel_carry = 1'b0;
            end
            2'b10: begin
                sel_data  = cmp_out;
                sel_flag  = cmp_flag;
                sel_carry = 1'b0;
            end
            default: begin
                sel_data  = shift_out;
                sel_flag  = shift_flag;
                sel_carry = 1'b0;
            end
        endcase
    end

    // Issue stage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            stg_valid <= 1'b0;
            stg_fun   <= 4'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            stg_valid <= op_valid;
            stg_fun   <= alu_fun;
            if (push) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            if (push && !pop) begin
                count <= count + cnt_w'(1);
            end else if (pop && !push) begin
                count <= count - cnt_w'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage is left unreset; empty gating hides stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= sel_data;
            mem_fun[wr_ptr]   <= stg_fun;
            mem_carry[wr_ptr] <= sel_carry;
            mem_flag[wr_ptr]  <= sel_flag;
        end
    end

    always_comb begin
        res_data  = '0;
        res_fun   = 4'b0;
        res_carry = 1'b0;
        res_flag  = 1'b0;
        if (!empty) begin
            res_data  = mem_data[rd_ptr];
            res_fun   = mem_fun[rd_ptr];
            res_carry = mem_carry[rd_ptr];
            res_flag  = mem_flag[rd_ptr];
        end
    end

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: directed table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_result_collector;

    localparam int unsigned wid   = 16;
    localparam int unsigned depth = 4;

    logic            clk;
    logic            rest;
    logic            op_valid;
    logic [3:0]      alu_fun;
    logic [wid-1:0]  ari_out, log_out, cmp_out, shift_out;
    logic            carry_out, ari_flag, log_flag, cmp_flag, shift_flag;
    logic [wid-1:0]  res_data;
    logic [3:0]      res_fun;
    logic            res_carry, res_flag, res_valid, res_ready;
    logic            full, empty, overflow, ovf_clr;
    logic [2:0]      count;

    int n_tests = 0;
    int n_fail  = 0;

    alu_result_collector #(.wid(wid), .depth(depth)) dut (
        .clk(clk), .rest(rest), .op_valid(op_valid), .alu_fun(alu_fun),
        .ari_out(ari_out), .log_out(log_out), .cmp_out(cmp_out), .shift_out(shift_out),
        .carry_out(carry_out), .ari_flag(ari_flag), .log_flag(log_flag),
        .cmp_flag(cmp_flag), .shift_flag(shift_flag),
        .res_data(res_data), .res_fun(res_fun), .res_carry(res_carry),
        .res_flag(res_flag), .res_valid(res_valid), .res_ready(res_ready),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a plain queue of results plus the issued op awaiting its unit output.
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  fun;
        logic        carry;
        logic        flag;
    } ent_t;

    ent_t       mq[$];
    logic       m_sv   = 1'b0;
    logic [3:0] m_sf   = 4'b0;
    logic       m_ovf  = 1'b0;
    logic       m_drop;
    ent_t       m_e;

    always @(posedge clk or negedge rest) begin
        if (!rest) begin
            mq.delete();
            m_sv  = 1'b0;
            m_sf  = 4'b0;
            m_ovf = 1'b0;
        end else begin
            m_drop = 1'b0;
            if (mq.size() != 0 && res_ready) void'(mq.pop_front());
            if (m_sv) begin
                m_e.fun = m_sf;
                case (m_sf[3:2])
                    2'b00:   begin m_e.data = ari_out;   m_e.flag = ari_flag;   m_e.carry = carry_out; end
                    2'b01:   begin m_e.data = log_out;   m_e.flag = log_flag;   m_e.carry = 1'b0; end
                    2'b10:   begin m_e.data = cmp_out;   m_e.flag = cmp_flag;   m_e.carry = 1'b0; end
                    default: begin m_e.data = shift_out; m_e.flag = shift_flag; m_e.carry = 1'b0; end
                endcase
                if (mq.size() < depth) mq.push_back(m_e);
                else m_drop = 1'b1;
            end
            if (m_drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_sv = op_valid;
            m_sf = alu_fun;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("m_valid", 32'(res_valid), 32'(mq.size() != 0));
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_full", 32'(full), 32'(mq.size() == depth));
        chk("m_empty", 32'(empty), 32'(mq.size() == 0));
        chk("m_ovf", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) begin
            chk("m_data", 32'(res_data), 32'(mq[0].data));
            chk("m_fun", 32'(res_fun), 32'(mq[0].fun));
            chk("m_carry", 32'(res_carry), 32'(mq[0].carry));
            chk("m_flag", 32'(res_flag), 32'(mq[0].flag));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        op;
        logic [3:0]  fun;
        logic        exp_rv;
        logic [15:0] exp_data;
        logic [3:0]  exp_fun;
        logic        exp_carry;
        logic        exp_flag;
        logic [2:0]  exp_cnt;
    } vec_t;

    vec_t        tbl[6];
    logic [15:0] drain_exp[4];

    initial begin
        // Routing table: units held at log=1111 cmp=2222 shift=3333 ari=4444, res_ready=1.
        tbl[0] = '{1'b1, 4'h4, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 4'h8, 1'b1, 16'h1111, 4'h4, 1'b0, 1'b1, 3'd1};
        tbl[2] = '{1'b1, 4'hC, 1'b1, 16'h2222, 4'h8, 1'b0, 1'b0, 3'd1};
        tbl[3] = '{1'b1, 4'h1, 1'b1, 16'h3333, 4'hC, 1'b0, 1'b1, 3'd1};
        tbl[4] = '{1'b0, 4'h0, 1'b1, 16'h4444, 4'h1, 1'b1, 1'b0, 3'd1};
        tbl[5] = '{1'b0, 4'h0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 3'd0};
        drain_exp[0] = 16'h0101;
        drain_exp[1] = 16'h0102;
        drain_exp[2] = 16'h0103;
        drain_exp[3] = 16'h0105;

        rest = 1'b0; op_valid = 1'b0; alu_fun = 4'h0; res_ready = 1'b0; ovf_clr = 1'b0;
        ari_out = '0; log_out = '0; cmp_out = '0; shift_out = '0;
        carry_out = 1'b0; ari_flag = 1'b0; log_flag = 1'b0; cmp_flag = 1'b0; shift_flag = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_fun", 32'(res_fun), 32'd0);
        rest = 1'b1;
        step();

        // Routing table
        ari_out = 16'h4444; log_out = 16'h1111; cmp_out = 16'h2222; shift_out = 16'h3333;
        carry_out = 1'b1; ari_flag = 1'b0; log_flag = 1'b1; cmp_flag = 1'b0; shift_flag = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op_valid = tbl[i].op;
            alu_fun  = tbl[i].fun;
            step();
            chk("tbl_valid", 32'(res_valid), 32'(tbl[i].exp_rv));
            chk("tbl_count", 32'(count), 32'(tbl[i].exp_cnt));
            if (tbl[i].exp_rv) begin
                chk("tbl_data", 32'(res_data), 32'(tbl[i].exp_data));
                chk("tbl_fun", 32'(res_fun), 32'(tbl[i].exp_fun));
                chk("tbl_carry", 32'(res_carry), 32'(tbl[i].exp_carry));
                chk("tbl_flag", 32'(res_flag), 32'(tbl[i].exp_flag));
            end
        end

        // Single arithmetic op: two-edge latency
        res_ready = 1'b0; carry_out = 1'b0;
        op_valid = 1'b1; alu_fun = 4'h0;
        step();
        chk("single_lat1", 32'(res_valid), 32'd0);
        op_valid = 1'b0; ari_out = 16'h0005; carry_out = 1'b1;
        step();
        chk("single_valid", 32'(res_valid), 32'd1);
        chk("single_data", 32'(res_data), 32'h5);
        chk("single_carry", 32'(res_carry), 32'd1);
        chk("single_fun", 32'(res_fun), 32'd0);
        res_ready = 1'b1;
        step();
        chk("single_pop", 32'(empty), 32'd1);

        // Fill past depth with consumer stalled
        res_ready = 1'b0; carry_out = 1'b0; alu_fun = 4'h0;
        for (int i = 0; i < 5; i++) begin
            op_valid = 1'b1;
            ari_out = 16'h00FF + 16'(i);
            step();
        end
        op_valid = 1'b0; ari_out = 16'h0104;
        step();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ovf", 32'(overflow), 32'd1);
        chk("fill_head", 32'(res_data), 32'h100);

        ovf_clr = 1'b1;
        step();
        chk("clr_ovf", 32'(overflow), 32'd0);
        ovf_clr = 1'b0;

        // Full with simultaneous pop and push
        op_valid = 1'b1;
        step();
        op_valid = 1'b0; res_ready = 1'b1; ari_out = 16'h0105;
        step();
        chk("fullpp_count", 32'(count), 32'd4);
        chk("fullpp_head", 32'(res_data), 32'h101);
        chk("fullpp_ovf", 32'(overflow), 32'd0);
        res_ready = 1'b0;

        // Clear coincident with a drop keeps overflow set
        op_valid = 1'b1;
        step();
        step();
        chk("drop_ovf", 32'(overflow), 32'd1);
        op_valid = 1'b0; ovf_clr = 1'b1;
        step();
        chk("clr_drop_ovf", 32'(overflow), 32'd1);
        step();
        chk("clr_nodrop_ovf", 32'(overflow), 32'd0);
        ovf_clr = 1'b0;

        res_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_data", 32'(res_data), 32'(drain_exp[j]));
            step();
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-cycle with three entries stored
        res_ready = 1'b0;
        op_valid = 1'b1;
        repeat (3) step();
        op_valid = 1'b0;
        step();
        chk("arst_pre_count", 32'(count), 32'd3);
        #3 rest = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_data", 32'(res_data), 32'd0);
        #2 rest = 1'b1;
        op_valid = 1'b1; alu_fun = 4'h4; log_out = 16'hBEEF;
        step();
        chk("arst_lat1", 32'(res_valid), 32'd0);
        op_valid = 1'b0;
        step();
        chk("arst_lat2", 32'(res_valid), 32'd1);
        chk("arst_data2", 32'(res_data), 32'hBEEF);

        // Randomized traffic: stalled consumer first, then mostly ready
        for (int i = 0; i < 400; i++) begin
            op_valid   = 1'($urandom_range(0, 3) != 0);
            alu_fun    = 4'($urandom);
            ari_out    = 16'($urandom);
            log_out    = 16'($urandom);
            cmp_out    = 16'($urandom);
            shift_out  = 16'($urandom);
            carry_out  = 1'($urandom);
            ari_flag   = 1'($urandom);
            log_flag   = 1'($urandom);
            cmp_flag   = 1'($urandom);
            shift_flag = 1'($urandom);
            ovf_clr    = 1'($urandom_range(0, 9) == 0);
            res_ready  = (i < 200) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
ALU_RESULT_COLLECTOR -- requirements
Module: alu_result_collector

Interface
REQ-001 The module SHALL have parameter wid, default 16, operand/result width.
REQ-002 The module SHALL have parameter depth, default 4, result FIFO entries (power of 2, >=2).
REQ-003 The module SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The module SHALL have port rest  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port op_valid  input  1  an operation is presented to the ALU this cycle.
REQ-006 The module SHALL have port alu_fun  input  4  opcode presented to the ALU with op_valid.
REQ-007 The module SHALL have ports ari_out, log_out, cmp_out, shift_out  input  wid each  registered ALU unit results.
REQ-008 The module SHALL have ports carry_out, ari_flag, log_flag, cmp_flag, shift_flag  input  1 each  ALU unit carry/flags.
REQ-009 The module SHALL have port res_data  output  wid  head-of-FIFO result.
REQ-010 The module SHALL have port res_fun  output  4  opcode of head result.
REQ-011 The module SHALL have port res_carry  output  1  carry of head result (0 for non-arithmetic ops).
REQ-012 The module SHALL have port res_valid  output  1  head entry valid.
REQ-013 The module SHALL have port res_ready  input  1  consumer accepts head.
REQ-014 The module SHALL have ports full, empty  output  1 each  FIFO status.
REQ-015 The module SHALL have port count  output  $clog2(depth+1)  FIFO occupancy.
REQ-016 The module SHALL have port overflow  output  1  sticky: a result was dropped.
REQ-017 The module SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-018 Issue stage: at each edge, stg_valid <= op_valid and stg_fun <= alu_fun (ALU units are registered, so their outputs match stg_fun one cycle later).
REQ-019 Select by stg_fun[3:2]: 00 -> ari_out/ari_flag/carry_out; 01 -> log_out/log_flag; 10 -> cmp_out/cmp_flag; 11 -> shift_out/shift_flag; carry stored as 0 for 01/10/11.
REQ-020 Push: when stg_valid=1, the entry {selected data, selected flag, carry, stg_fun} SHALL be written at the next edge if !full or a pop occurs that same edge.
REQ-021 Latency: op_valid at edge k -> entry written at edge k+1 -> res_valid=1 after edge k+1 (FIFO empty before).
REQ-022 Pop: occurs at an edge where res_valid=1 and res_ready=1; the head advances.
REQ-023 FIFO is first-word-fall-through: res_data/res_fun/res_carry/res_flag reflect the head entry whenever res_valid=1; they are don't-care when res_valid=0.
REQ-024 res_flag  output  1  flag of head result (additional port, same group as REQ-009).
REQ-025 res_valid = !empty; empty = (count==0); full = (count==depth).
REQ-026 Simultaneous push and pop: count unchanged, including at full and at count==1.
REQ-027 Pointers SHALL wrap modulo depth; no entry is lost or duplicated at wrap.
REQ-028 Drop: stg_valid=1 with full=1 and no pop -> entry discarded, overflow <= 1 at that edge.
REQ-029 overflow stays 1 until an edge with ovf_clr=1 and no new drop; a drop on the same edge as ovf_clr leaves overflow=1.
REQ-030 Back-to-back op_valid every cycle SHALL be accepted without bubbles while not full.

Reset
REQ-031 rest=0 SHALL immediately, without clk, clear stg_valid, stg_fun, pointers, count, overflow; outputs: res_valid=0, empty=1, full=0, count=0, overflow=0, res_data/res_fun/res_carry/res_flag=0.
REQ-032 Reset mid-operation SHALL discard staged and stored results; first op_valid after rest rises is handled as from empty.
REQ-033 FIFO storage array need not be reset.

Verification
REQ-034 Single op: op_valid=1, alu_fun=4'b0000, ari_out=16'h0005 next cycle, carry_out=1 -> res_valid=1 after 2nd edge, res_data=16'h0005, res_carry=1, res_fun=0.
REQ-035 Routing: four ops alu_fun=0x4,0x8,0xC,0x1 with distinct unit outputs 16'h1111/2222/3333/4444 on matching units, res_ready=1 -> results pop in order with matching res_fun, res_carry=0 for first three.
REQ-036 Fill/overflow: res_ready=0, 5 consecutive ops (depth=4) -> full=1 and count=4 after 5th write edge, overflow=1, first 4 results retained in order.
REQ-037 Full with simultaneous pop: full, res_ready=1, stg_valid=1 -> count stays 4, head advances, overflow stays 0.
REQ-038 Overflow clear: overflow=1, ovf_clr=1 one cycle with no drop -> overflow=0; ovf_clr coincident with drop -> overflow stays 1.
REQ-039 Async reset: assert rest=0 between clk edges with count=3 -> count=0, empty=1, res_valid=0 immediately; first op after release produces res_valid 2 edges later.
